fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of the out-of-order core. Generates sequential PCs, issues requests to instruction memory, buffers returned words in an in-order instruction buffer, and presents them with their PC to the decode stage over a valid/ready handshake. Redirects from branch/JALR resolution restart fetch at a new PC and discard every in-flight or buffered instruction from the old path.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: instruction buffer entries and maximum in-flight requests; power of two, ≥2.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  input  32  returned instruction word.
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] ignored (treated as 0).
- dec_valid  output  1  instruction available to decode.
- dec_ready  input  1  decode accepts this cycle.
- dec_instr  output  32  instruction word at buffer head.
- dec_pc  output  32  PC of dec_instr.

## Operation
- State: fetch_pc, resp_pc, instruction buffer (DEPTH entries of {pc, instr}), out_cnt (requests accepted, response not yet returned), drop_cnt (subset of out_cnt to be discarded). Counters $clog2(DEPTH)+1 bits.
- Request: imem_req_valid = !reset && !redirect_valid && (occupancy + out_cnt < DEPTH). imem_req_addr = fetch_pc. On req handshake: fetch_pc += 4 (mod 2^32, wraps), out_cnt += 1.
- Response: out_cnt -= 1. If drop_cnt > 0: drop_cnt -= 1, word discarded. Else push {resp_pc, imem_rsp_data}, resp_pc += 4.
- Credit rule guarantees a kept response never meets a full buffer; no response is ever lost or overwritten.
- Decode: dec_valid = !empty && !redirect_valid; dec_instr/dec_pc = head entry. Pop on dec_valid && dec_ready.
- Redirect (priority over everything): buffer cleared; fetch_pc <= resp_pc <= {redirect_pc[31:2],2'b00}; drop_cnt <= out_cnt minus 1 if a response arrives that cycle (that response is itself dropped); out_cnt updated normally for the arriving response. No request and no decode transfer occur in the redirect cycle.
- Redirect while drop_cnt > 0: drop_cnt recomputed as above (all old-path responses still dropped).
- Simultaneous push and pop: occupancy unchanged, both performed.

## Timing
- Reset values: imem_req_valid=0, dec_valid=0, fetch_pc=resp_pc=RESET_PC, out_cnt=drop_cnt=0, buffer empty; dec_instr/dec_pc don't-care while dec_valid=0.
- First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.
- Response in cycle N -> dec_valid in cycle N+1 (buffer registered; no bypass).
- Redirect in cycle R -> imem_req_addr=redirect_pc in R+1 (request issued if credit allows); earliest new-path dec_valid is the cycle after its response.
- Reset mid-operation: all state returns to reset values next edge; responses to pre-reset requests are the memory's responsibility to suppress.
- Back-to-back throughput: 1 instruction/cycle sustained when memory accepts every cycle and decode is always ready.

## Structure
- Shared package riscv_pkg: XLEN=32, INSTR_BYTES=4, typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, push/pop/flush, full/empty/count outputs, wrap-around pointers with extra MSB.

## Test plan
- Reset release, memory always ready, latency 1, decode always ready -> requests 0x0,0x4,0x8…; dec_pc 0x0 appears 2 cycles after first request, one per cycle thereafter.
- dec_ready held 0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; release dec_ready -> fetching resumes at 0x10, order preserved.
- 3 requests in flight, redirect_pc=0x100 -> next 3 responses discarded, first dec_pc=0x100 with its matching word, no old-path instruction reaches decode.
- Redirect coincident with a response and with dec_ready=1 -> that response dropped, dec_valid=0 that cycle, drop_cnt=out_cnt-1.
- Second redirect (0x200) while draining first -> only 0x200 path delivered; redirect_pc=0x203 fetches 0x200.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000; reset asserted mid-stream -> next cycle dec_valid=0, request at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: data width, instruction size and the fetch buffer entry.
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: synchronous FIFO of fetch entries with a flush.
// Pointers carry one extra MSB so full and empty can be told apart.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests,
// in-order buffering, and redirect flush with dropping of old-path responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_din;
    fetch_entry_t    fifo_head;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Buffered plus in-flight words never exceed DEPTH, so a kept response always fits.
    assign credit_used    = {1'b0, occupancy} + {1'b0, out_cnt};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && !fifo_full;
    assign dec_valid = !fifo_empty && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = fifo_head.instr;
    assign dec_pc    = fifo_head.pc;
    assign fifo_din  = '{pc: resp_pc, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old path.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                drop_cnt <= out_cnt - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                if (push)     resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with random latency,
// plus a queue-based reference of in-flight requests and buffered instructions.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } flight_t;

    mem_req_t     mq[$];
    flight_t      infl[$];
    fetch_entry_t mbuf[$];
    logic [31:0]  m_fetch_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    int          k_ready_pct = 100;
    int          k_dec_pct   = 100;
    int          k_lat_min   = 1;
    int          k_lat_max   = 1;
    int          k_redir_pct = 0;
    int          k_rst_pm    = 0;
    bit          k_reset     = 0;
    bit          k_redirect  = 0;
    logic [31:0] k_redirect_pc = '0;
    bit          prev_redir  = 0;

    logic        s_rv, s_rdy, s_dv;
    logic [31:0] s_ra, s_dpc, s_dinstr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5EED_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit          exp_rv, exp_dv;
        fetch_entry_t e;
        flight_t     f;
        reset          = k_reset || ($urandom_range(999) < k_rst_pm);
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (!reset) begin
            if (k_redirect) begin
                redirect_valid = 1'b1;
                redirect_pc    = k_redirect_pc;
            end else if (!prev_redir && ($urandom_range(99) < k_redir_pct)) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                          : $urandom;
            end
        end
        imem_req_ready = ($urandom_range(99) < k_ready_pct);
        dec_ready      = ($urandom_range(99) < k_dec_pct);
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #3;
        exp_rv = !reset && !redirect_valid && ((mbuf.size() + infl.size()) < DEPTH);
        exp_dv = (mbuf.size() > 0) && !redirect_valid;
        if (chk_en) begin
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
            check("dec_valid", 32'(dec_valid), 32'(exp_dv));
            if (exp_dv) begin
                check("dec_pc", dec_pc, mbuf[0].pc);
                check("dec_instr", dec_instr, mbuf[0].instr);
            end
        end
        s_rv = imem_req_valid; s_rdy = imem_req_ready; s_ra = imem_req_addr;
        s_dv = dec_valid; s_dpc = dec_pc; s_dinstr = dec_instr;

        if (reset) begin
            mbuf.delete();
            infl.delete();
            m_fetch_pc = RESET_PC;
        end else begin
            if (exp_dv && dec_ready) void'(mbuf.pop_front());
            if (imem_rsp_valid) begin
                if (infl.size() == 0) begin
                    check("rsp_has_request", 32'd0, 32'd1);
                end else begin
                    f = infl.pop_front();
                    if (!f.stale && !redirect_valid) begin
                        e.pc    = f.addr;
                        e.instr = imem_rsp_data;
                        mbuf.push_back(e);
                    end
                end
            end
            if (redirect_valid) begin
                mbuf.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (exp_rv && imem_req_ready) begin
                f.addr  = m_fetch_pc;
                f.stale = 1'b0;
                infl.push_back(f);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end

        if (reset) begin
            mq.delete();
        end else begin
            mem_req_t r;
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + $urandom_range(k_lat_max, k_lat_min);
                if (mq.size() > 0 && r.due < mq[$].due) r.due = mq[$].due;
                mq.push_back(r);
            end
        end
        prev_redir = redirect_valid;
        k_redirect = 0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        k_reset = 1;
        cycle();
        k_reset = 0;
    endtask

    task automatic find_first_dec(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_dv) begin
                found = 1;
                check({name, "_pc"}, s_dpc, exp_pc);
                check({name, "_instr"}, s_dinstr, mem_word(exp_pc));
            end
        end
        check({name, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        int n;
        bit found;
        reset = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
        m_fetch_pc = RESET_PC;
        @(posedge clk); #1;

        // Reset release, latency 1, everything ready.
        k_reset = 1; chk_en = 0; cycle();
        chk_en = 1; cycle(); cycle();
        k_reset = 0;
        cycle();
        check("first_req_valid", 32'(s_rv), 32'd1);
        check("first_req_addr", s_ra, RESET_PC);
        cycle();
        check("second_req_addr", s_ra, 32'h4);
        check("no_bypass", 32'(s_dv), 32'd0);
        cycle();
        check("first_dec_valid", 32'(s_dv), 32'd1);
        check("first_dec_pc", s_dpc, 32'h0);
        check("first_dec_instr", s_dinstr, mem_word(32'h0));
        cycle();
        check("stream_dec_pc", s_dpc, 32'h4);

        // Decode stalled: buffer fills and requests stop at DEPTH.
        k_dec_pct = 0;
        do_reset();
        n = 0;
        repeat (10) begin
            cycle();
            if (s_rv && s_rdy) n++;
        end
        check("bp_req_count", 32'(n), 32'd4);
        check("bp_req_stopped", 32'(s_rv), 32'd0);
        k_dec_pct = 100;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (s_rv) begin
                found = 1;
                check("bp_resume_addr", s_ra, 32'h10);
            end
        end
        check("bp_resume_seen", 32'(found), 32'd1);

        // Redirect with three requests in flight.
        k_lat_min = 4; k_lat_max = 4;
        do_reset();
        repeat (3) cycle();
        k_redirect = 1; k_redirect_pc = 32'h100;
        cycle();
        check("redir_no_req", 32'(s_rv), 32'd0);
        find_first_dec("redir_first", 32'h100);

        // Redirect coinciding with a response and a ready decode.
        k_lat_min = 1; k_lat_max = 1;
        do_reset();
        repeat (5) cycle();
        k_redirect = 1; k_redirect_pc = 32'h40;
        cycle();
        check("redir_rsp_dec_valid", 32'(s_dv), 32'd0);
        check("redir_rsp_req_valid", 32'(s_rv), 32'd0);
        cycle();
        check("redir_rsp_next_addr", s_ra, 32'h40);

        // Second redirect while the first is draining; misaligned target.
        k_lat_min = 4; k_lat_max = 4;
        do_reset();
        repeat (2) cycle();
        k_redirect = 1; k_redirect_pc = 32'h100;
        cycle();
        repeat (2) cycle();
        k_redirect = 1; k_redirect_pc = 32'h203;
        cycle();
        cycle();
        check("redir2_addr", s_ra, 32'h200);
        find_first_dec("redir2_first", 32'h200);

        // PC wrap, then reset in mid-stream.
        k_lat_min = 1; k_lat_max = 1;
        k_redirect = 1; k_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        cycle();
        check("wrap_addr_top", s_ra, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr_zero", s_ra, 32'h0);
        repeat (3) cycle();
        do_reset();
        cycle();
        check("mid_reset_dec_valid", 32'(s_dv), 32'd0);
        check("mid_reset_req_valid", 32'(s_rv), 32'd1);
        check("mid_reset_req_addr", s_ra, RESET_PC);

        // Randomized traffic.
        for (int blk = 0; blk < 20; blk++) begin
            k_ready_pct = $urandom_range(100, 30);
            k_dec_pct   = $urandom_range(100, 20);
            k_lat_min   = 1;
            k_lat_max   = $urandom_range(6, 1);
            k_redir_pct = $urandom_range(8, 0);
            k_rst_pm    = $urandom_range(3, 0);
            repeat (200) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
